// File: rtl/byte_elastic_buffer.sv
// Single-clock elastic byte FIFO with valid/ready on both sides, first-word-fall-through read,
// a registered fill level driving in_ready/out_valid/almost_full, and a synchronous flush.
module byte_elastic_buffer #(
    parameter int DW        = 8,
    parameter int DEPTH     = 4,
    parameter int AW        = 2,
    parameter int AFULL_LVL = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW:0]   level,
    output logic          almost_full
);

    localparam logic [AW:0] LVL_FULL  = (AW+1)'(DEPTH);
    localparam logic [AW:0] LVL_AFULL = (AW+1)'(AFULL_LVL);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    // Status comes only from the level register, so a same-cycle pop never
    // reopens in_ready and a same-cycle push is never forwarded to the output.
    assign in_ready    = (level != LVL_FULL);
    assign out_valid   = (level != '0);
    assign almost_full = (level >= LVL_AFULL);

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    assign out_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: tb/tb_byte_elastic_buffer.sv
// Directed bench for byte_elastic_buffer: reset, fill/full, drain order, wrap streaming,
// random backpressure with a scoreboard, and flush priority.
module tb_byte_elastic_buffer;

    logic       clk;
    logic       rst;
    logic       flush;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] level;
    logic       almost_full;

    int checks = 0;
    int errors = 0;

    byte_elastic_buffer #(.DW(8), .DEPTH(4), .AW(2), .AFULL_LVL(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .level       (level),
        .almost_full (almost_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    logic [7:0] exp_q [4];
    int tx, rx, lvl_max, seed_init;
    logic do_push, do_pop;

    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        seed_init = $urandom(32'd1234);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("rst_level", 32'(level), 32'd0);
        check_val("rst_ovalid", 32'(out_valid), 32'd0);
        check_val("rst_iready", 32'(in_ready), 32'd1);
        check_val("rst_afull", 32'(almost_full), 32'd0);
        @(negedge clk);

        // Two pushes, then an asynchronous reset mid-cycle
        in_valid = 1'b1; in_data = 8'hA1; tick();
        in_data = 8'hA2; tick();
        in_valid = 1'b0;
        check_val("pre_rst_level", 32'(level), 32'd2);
        #2 rst = 1'b0;
        #1;
        check_val("mid_rst_level", 32'(level), 32'd0);
        check_val("mid_rst_ovalid", 32'(out_valid), 32'd0);
        check_val("mid_rst_iready", 32'(in_ready), 32'd1);
        check_val("mid_rst_afull", 32'(almost_full), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'h5A; tick();
        in_valid = 1'b0;
        check_val("post_rst_ovalid", 32'(out_valid), 32'd1);
        check_val("post_rst_data", 32'(out_data), 32'h5A);
        check_val("post_rst_level", 32'(level), 32'd1);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        check_val("post_rst_empty", 32'(out_valid), 32'd0);

        // Fill to full with the consumer stalled
        exp_q[0] = 8'h11; exp_q[1] = 8'h22; exp_q[2] = 8'h33; exp_q[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = exp_q[i]; tick();
            check_val("fill_level", 32'(level), 32'(i + 1));
            check_val("fill_afull", 32'(almost_full), (i >= 2) ? 32'd1 : 32'd0);
        end
        check_val("full_iready", 32'(in_ready), 32'd0);
        in_data = 8'h55;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("full_hold_level", 32'(level), 32'd4);
            check_val("full_hold_head", 32'(out_data), 32'h11);
        end
        in_valid = 1'b0;

        // Drain in order
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_val("drain_ovalid", 32'(out_valid), 32'd1);
            check_val("drain_data", 32'(out_data), 32'(exp_q[i]));
            tick();
            check_val("drain_level", 32'(level), 32'(3 - i));
            check_val("drain_iready", 32'(in_ready), 32'd1);
        end
        check_val("drain_empty", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // Continuous streaming through several pointer wraps
        in_valid = 1'b1; in_data = 8'h00; tick();
        for (int i = 1; i < 16; i++) begin
            in_data = 8'(i); out_ready = 1'b1;
            check_val("strm_ovalid", 32'(out_valid), 32'd1);
            check_val("strm_data", 32'(out_data), 32'(i - 1));
            check_val("strm_level", 32'(level), 32'd1);
            check_val("strm_iready", 32'(in_ready), 32'd1);
            tick();
        end
        in_valid = 1'b0;
        check_val("strm_last", 32'(out_data), 32'h0F);
        tick();
        check_val("strm_end_level", 32'(level), 32'd0);
        out_ready = 1'b0;

        // Random backpressure against a scoreboard
        tx = 0; rx = 0; lvl_max = 0;
        for (int c = 0; c < 400 && rx < 32; c++) begin
            in_valid = (tx < 32);
            in_data = 8'(8'h80 + tx);
            out_ready = 1'($urandom_range(0, 1));
            #1;
            if (int'(level) > lvl_max) lvl_max = int'(level);
            do_push = in_valid && in_ready;
            do_pop = out_valid && out_ready;
            if (do_pop) begin
                check_val("sb_data", 32'(out_data), 32'(8'h80 + rx));
                rx++;
            end
            tick();
            if (do_push) tx++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        check_val("sb_count", 32'(rx), 32'd32);
        check_val("sb_lvl_max_ok", (lvl_max <= 4) ? 32'd1 : 32'd0, 32'd1);
        @(negedge clk);
        check_val("sb_end_level", 32'(level), 32'd0);

        // Flush wins over a concurrent push and pop
        in_valid = 1'b1; in_data = 8'hC1; tick();
        in_data = 8'hC2; tick();
        check_val("fl_pre_level", 32'(level), 32'd2);
        in_data = 8'h77; out_ready = 1'b1; flush = 1'b1; tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        check_val("fl_level", 32'(level), 32'd0);
        check_val("fl_ovalid", 32'(out_valid), 32'd0);
        check_val("fl_iready", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_data = 8'h99; tick();
        in_valid = 1'b0;
        check_val("fl_next_ovalid", 32'(out_valid), 32'd1);
        check_val("fl_next_data", 32'(out_data), 32'h99);
        check_val("fl_next_level", 32'(level), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/byte_elastic_buffer.md
Name: byte_elastic_buffer

Overview:
- Synchronous elastic FIFO between the 8-bit registered byte producer stage and the 8-bit byte capture stage. All three stages share one clock.
- Decouples the two stages with a valid/ready handshake on each side, so the producer can run ahead by up to DEPTH bytes.
- Exposes fill level and almost-full status for upstream flow control.
- Provides a synchronous flush.

Parameters:
- DW, 8, data width in bits.
- DEPTH, 4, number of entries; must be a power of 2 and ≥2.
- AW, 2, pointer width, equal to log2(DEPTH).
- AFULL_LVL, 3, almost_full asserts when level ≥ AFULL_LVL; legal range is 1..DEPTH.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous clear of contents; active high.
- in_data  input  DW  byte from upstream producer.
- in_valid  input  1  upstream presents in_data.
- in_ready  output  1  buffer can accept a byte this cycle.
- out_data  output  DW  byte to downstream consumer.
- out_valid  output  1  out_data holds the oldest stored byte.
- out_ready  input  1  downstream accepts out_data this cycle.
- level  output  AW+1  number of stored entries, 0..DEPTH.
- almost_full  output  1  level ≥ AFULL_LVL.

Behaviour:
- Reset: clk and rst are as already decided, with reset asynchronous and active-low.
  - While rst=0, clear wr_ptr, rd_ptr and level to 0.
  - Reset outputs: in_ready=1, out_valid=0, level=0, almost_full=0.
  - out_data reset value is don't-care; the bench masks it while out_valid=0.
  - Storage array is not reset.
- Pointers: wr_ptr and rd_ptr are AW bits wide and wrap modulo DEPTH, i.e. DEPTH-1 → 0.
- Level register: level is a separate register of AW+1 bits.
- Combinational status:
  - in_ready = (level != DEPTH).
  - out_valid = (level != 0).
  - almost_full = (level ≥ AFULL_LVL).
  - All three are decoded directly from the level register.
- Read path: out_data = mem[rd_ptr], first-word-fall-through.
  - The value is stable while out_valid=1 and out_ready=0.
- Push: push = in_valid & in_ready.
  - On posedge, write mem[wr_ptr] <= in_data, then wr_ptr++.
- Pop: pop = out_valid & out_ready.
  - On posedge, rd_ptr++.
- Level update:
  - push only: level+1.
  - pop only: level-1.
  - both: level unchanged, memory written, both pointers advance.
  - neither: unchanged.
- Latency: a byte pushed at edge N is visible with out_valid=1 in the cycle after edge N. Minimum in-to-out latency is 1 cycle; there is no combinational pass-through.
- Full (level=DEPTH):
  - in_ready=0, so in_valid is ignored and memory is not written.
  - A pop in the same cycle does NOT raise in_ready combinationally; in_ready returns the cycle after the pop.
- Empty (level=0):
  - out_valid=0, so out_ready is ignored and rd_ptr holds.
  - A push in the same cycle is not forwarded.
- Simultaneous push and pop at level 1..DEPTH-1: level is unchanged and ordering is preserved.
- flush=1 at posedge:
  - wr_ptr, rd_ptr and level go to 0.
  - Any concurrent push or pop is discarded.
  - flush has priority over everything except rst.
- rst asserted mid-transfer: immediate clear regardless of clk. After rst is released, the first byte is accepted at the first posedge with in_valid=1.
- Handshake rules on the interfaces:
  - Upstream must hold in_data and in_valid while in_ready=0; the buffer never drops an accepted byte.
  - Downstream may toggle out_ready freely.
- Data integrity: bytes leave in strict arrival order with no duplication or loss.

Test Plan (DEPTH=4, AFULL_LVL=3):
- Reset and idle: assert rst=0 mid-sim after 2 pushes → in the same cycle level=0, out_valid=0, in_ready=1, almost_full=0. After release, push 0x5A → next cycle out_valid=1, out_data=0x5A.
- Fill to full: push 0x11, 0x22, 0x33, 0x44 with out_ready=0 → after the 3rd push almost_full=1; after the 4th, level=4 and in_ready=0. Then hold in_valid with 0x55 for 3 cycles → level stays 4 and 0x55 is not stored.
- Drain and order: from full, set out_ready=1 → outputs 0x11, 0x22, 0x33, 0x44 on consecutive cycles; level goes 3, 2, 1, 0; out_valid=0 after the last; in_ready=1 from the cycle after the first pop.
- Streaming with wrap: push 0x00..0x0F continuously with out_ready=1 from cycle 2 → level steady at 1, output sequence 0x00..0x0F with no gaps, pointers wrap 4 times, and no stall after the first byte.
- Backpressure toggling: random out_ready (seed-fixed, ~50%) with continuous pushes of 0x80..0x9F → scoreboard receives all 32 bytes in order and level never exceeds 4.
- Flush priority: at level=2, drive flush=1 together with push 0x77 and out_ready=1 → next cycle level=0, out_valid=0; a following push of 0x99 appears as the next out_data.
